stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_core_tick_gen.sv | 25 ++
 rtl/stopwatch_core.sv | 135 +++++++++++++
 tb/tb_stopwatch_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, counter limits and display formatting
// for the stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam int CSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int DISP_W   = 14;

    function automatic logic [DISP_W-1:0] disp_fmt(
        input logic       sel,
        input logic [5:0] mm,
        input logic [5:0] ss,
        input logic [6:0] cc
    );
        return sel ? DISP_W'(mm) * DISP_W'(100) + DISP_W'(ss)
                   : DISP_W'(ss) * DISP_W'(100) + DISP_W'(cc);
    endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV enabled clocks;
// holds its phase while disabled, clear forces it back to zero.
module tick_gen #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: run/stop/clear stopwatch producing 0..5999 for the FND controller.
// Define STOPWATCH_LAP_EN to add btn_lap and a frozen lap display.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic              btn_lap,
`endif
    input  logic              disp_sel,
    output logic [DISP_W-1:0] disp_data,
    output logic              running,
    output logic              rollover
);
    state_t            state, state_nx;
    logic              armed, run_d1, clear_d1, run_edge, clear_edge, tick;
    logic [6:0]        csec;
    logic [5:0]        sec, min;
    logic              c_wrap, s_wrap, m_wrap;
    logic [DISP_W-1:0] disp_nx;

    // armed masks edges for the first cycle after reset, so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (reset) begin
            armed    <= 1'b0;
            run_d1   <= 1'b0;
            clear_d1 <= 1'b0;
        end else begin
            armed    <= 1'b1;
            run_d1   <= btn_run;
            clear_d1 <= btn_clear;
        end
    end

    assign run_edge   = armed && btn_run && !run_d1;
    assign clear_edge = armed && btn_clear && !clear_d1;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run_edge ? RUN : IDLE;
            RUN:     state_nx = run_edge ? STOP : RUN;
            STOP:    state_nx = clear_edge ? IDLE : (run_edge ? RUN : STOP);
            default: state_nx = IDLE;
        endcase
    end

    tick_gen #(.DIV(CLK_FREQ_HZ / TICK_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == RUN),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    assign c_wrap = csec == 7'(CSEC_MAX);
    assign s_wrap = sec == 6'(SEC_MAX);
    assign m_wrap = min == 6'(MIN_MAX);

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            csec <= '0;
            sec  <= '0;
            min  <= '0;
        end else if (tick) begin
            csec <= c_wrap ? 7'd0 : csec + 7'd1;
            if (c_wrap)
                sec <= s_wrap ? 6'd0 : sec + 6'd1;
            if (c_wrap && s_wrap)
                min <= m_wrap ? 6'd0 : min + 6'd1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_d1, lap_edge, frozen;
    logic [6:0] snap_csec;
    logic [5:0] snap_sec, snap_min;

    assign lap_edge = armed && btn_lap && !lap_d1;

    // snapshot keeps the raw counters so disp_sel can re-format a frozen lap
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_d1    <= 1'b0;
            frozen    <= 1'b0;
            snap_csec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
        end else begin
            lap_d1 <= btn_lap;
            if (state_nx == IDLE)
                frozen <= 1'b0;
            else if (lap_edge && frozen)
                frozen <= 1'b0;
            else if (lap_edge && state == RUN) begin
                frozen    <= 1'b1;
                snap_csec <= csec;
                snap_sec  <= sec;
                snap_min  <= min;
            end
        end
    end

    assign disp_nx = frozen ? disp_fmt(disp_sel, snap_min, snap_sec, snap_csec)
                            : disp_fmt(disp_sel, min, sec, csec);
`else
    assign disp_nx = disp_fmt(disp_sel, min, sec, csec);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data <= '0;
            running   <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            disp_data <= disp_nx;
            running   <= state_nx == RUN;
            rollover  <= tick && c_wrap && s_wrap && m_wrap;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed table-driven checks of stopwatch_core at 10 clocks per tick,
// plus hand-written sequences for phase keeping, clear priority, rollover and lap.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset, btn_run, btn_clear, disp_sel;
    logic [13:0] disp_data;
    logic        running, rollover;
`ifdef STOPWATCH_LAP_EN
    logic        btn_lap;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          ticks;
        logic [13:0] exp_ss;
        logic [13:0] exp_mm;
    } vec_t;

    vec_t vecs[4];

    stopwatch_core #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
`endif
        .disp_sel  (disp_sel),
        .disp_data (disp_data),
        .running   (running),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input logic r, input logic c);
        btn_run   = r;
        btn_clear = c;
        step(1);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic press_lap();
        btn_lap = 1'b1;
        step(1);
        btn_lap = 1'b0;
    endtask
`endif

    initial begin
        vecs[0] = '{ticks: 7,    exp_ss: 14'd7,   exp_mm: 14'd0};
        vecs[1] = '{ticks: 123,  exp_ss: 14'd123, exp_mm: 14'd1};
        vecs[2] = '{ticks: 345,  exp_ss: 14'd345, exp_mm: 14'd3};
        vecs[3] = '{ticks: 6000, exp_ss: 14'd0,   exp_mm: 14'd100};

        reset     = 1'b1;
        btn_run   = 1'b1;
        btn_clear = 1'b0;
        disp_sel  = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap   = 1'b0;
`endif
        step(3);
        check("rst_disp", disp_data, 0);
        check("rst_running", running, 0);
        check("rst_rollover", rollover, 0);
        reset = 1'b0;
        step(5);
        check("held_run_running", running, 0);
        check("held_run_disp", disp_data, 0);
        btn_run = 1'b0;
        step(3);
        check("held_release_running", running, 0);

        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0);
            step(10 * vecs[i].ticks + 3);
            check($sformatf("v%0d_live", i), disp_data, vecs[i].exp_ss);
            check($sformatf("v%0d_running", i), running, 1);
            press(1'b1, 1'b0);
            check($sformatf("v%0d_stopped", i), running, 0);
            check($sformatf("v%0d_stop_ss", i), disp_data, vecs[i].exp_ss);
            step(20);
            check($sformatf("v%0d_hold_ss", i), disp_data, vecs[i].exp_ss);
            disp_sel = 1'b1;
            step(1);
            check($sformatf("v%0d_stop_mm", i), disp_data, vecs[i].exp_mm);
            disp_sel = 1'b0;
            press(1'b0, 1'b1);
            step(2);
            check($sformatf("v%0d_clear_disp", i), disp_data, 0);
            check($sformatf("v%0d_clear_running", i), running, 0);
        end

        // stop at prescaler phase 4, resume: next tick lands exactly 6 clocks later
        press(1'b1, 1'b0);
        step(53);
        press(1'b1, 1'b0);
        check("phase_stop_disp", disp_data, 5);
        step(50);
        check("phase_hold_disp", disp_data, 5);
        check("phase_hold_running", running, 0);
        press(1'b1, 1'b0);
        step(5);
        check("phase_r5", disp_data, 5);
        step(1);
        check("phase_r6", disp_data, 5);
        step(1);
        check("phase_r7", disp_data, 6);
        press(1'b0, 1'b1);
        check("run_clear_running", running, 1);
        step(9);
        check("run_clear_counts", disp_data, 7);
        press(1'b1, 1'b0);
        check("stop_again", running, 0);
        press(1'b1, 1'b1);
        step(2);
        check("both_edges_disp", disp_data, 0);
        check("both_edges_running", running, 0);
        step(20);
        check("both_edges_idle", running, 0);
        press(1'b0, 1'b1);
        step(20);
        check("idle_clear_running", running, 0);
        check("idle_clear_disp", disp_data, 0);

        // preload 59:59.99 while stopped, then let one tick wrap it
        press(1'b1, 1'b0);
        step(3);
        press(1'b1, 1'b0);
        force dut.csec = 7'd99;
        force dut.sec  = 6'd59;
        force dut.min  = 6'd59;
        step(1);
        release dut.csec;
        release dut.sec;
        release dut.min;
        check("preload_ss", disp_data, 5999);
        disp_sel = 1'b1;
        step(1);
        check("preload_mm", disp_data, 5959);
        disp_sel = 1'b0;
        step(1);
        check("preload_kept", disp_data, 5999);
        check("preload_rollover", rollover, 0);
        press(1'b1, 1'b0);
        step(5);
        check("roll_before", rollover, 0);
        step(1);
        check("roll_pulse", rollover, 1);
        check("roll_disp_prev", disp_data, 5999);
        step(1);
        check("roll_after", rollover, 0);
        check("roll_disp_ss", disp_data, 0);
        disp_sel = 1'b1;
        step(1);
        check("roll_disp_mm", disp_data, 0);
        disp_sel = 1'b0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        step(2);
        check("roll_clear", disp_data, 0);

`ifdef STOPWATCH_LAP_EN
        press(1'b1, 1'b0);
        step(2503);
        check("lap_live", disp_data, 250);
        press_lap();
        check("lap_freeze", disp_data, 250);
        step(1000);
        check("lap_frozen", disp_data, 250);
        check("lap_running", running, 1);
        disp_sel = 1'b1;
        step(1);
        check("lap_frozen_mm", disp_data, 2);
        disp_sel = 1'b0;
        step(1);
        check("lap_frozen_ss", disp_data, 250);
        step(497);
        press_lap();
        step(1);
        check("lap_release", disp_data, 400);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        step(2);
        check("lap_clear", disp_data, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
